// File: rtl/cube_pkg.sv
// Shared definitions for the 8x8x8 LED cube scan logic.
package cube_pkg;

  localparam int unsigned CUBE_W     = 8;
  localparam int unsigned CUBE_H     = 8;
  localparam int unsigned CUBE_D     = 8;
  localparam int unsigned CUBE_CELLS = CUBE_W * CUBE_H * CUBE_D;
  localparam int unsigned LAYER_BITS = CUBE_W * CUBE_D;

  typedef enum logic [2:0] {
    StSync,
    StStep,
    StCapture,
    StShift,
    StLatch,
    StDwell
  } scan_state_e;

  // Linear cell index: x + 8y + 64z.
  function automatic logic [8:0] cell_idx(input logic [2:0] x, input logic [2:0] y,
                                          input logic [2:0] z);
    return {z, y, x};
  endfunction

endpackage

// File: rtl/cube_bit_shifter.sv
// Serialises one 64-bit layer: CLK_PER_BIT clocks per bit, bit index counts 63 down to 0.
module cube_bit_shifter
  import cube_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       bit_in,
  output logic       done,
  output logic [5:0] bit_idx,
  output logic       Ser_clk,
  output logic       Ser_data
);

  localparam int unsigned PhW  = $clog2(CLK_PER_BIT);
  localparam int unsigned Half = CLK_PER_BIT / 2;

  logic           active_q;
  logic [PhW-1:0] phase_q;
  logic [5:0]     n_q;
  logic           bit_end;

  assign bit_end = active_q && (phase_q == PhW'(CLK_PER_BIT - 1));
  assign done    = bit_end && (n_q == 6'd0);
  assign bit_idx = n_q;
  // Low for the first half of each bit, high for the second; data only moves as clk falls.
  assign Ser_clk  = active_q && (phase_q >= PhW'(Half));
  assign Ser_data = active_q && bit_in;

  // Bit-period divider and bit counter.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      active_q <= 1'b0;
      phase_q  <= '0;
      n_q      <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      phase_q  <= '0;
      n_q      <= 6'(LAYER_BITS - 1);
    end else if (active_q) begin
      if (bit_end) begin
        phase_q <= '0;
        if (n_q == 6'd0) begin
          active_q <= 1'b0;
        end else begin
          n_q <= n_q - 6'd1;
        end
      end else begin
        phase_q <= phase_q + PhW'(1);
      end
    end
  end

endmodule

// File: rtl/cube_scan_ctrl.sv
// Scan/step controller: paces generation steps and scans a snapshotted frame layer by layer.
module cube_scan_ctrl
  import cube_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 4,
  parameter int unsigned DWELL_CYC   = 1024,
  parameter int unsigned GEN_DIV     = 1_000_000
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Run,
  input  logic [511:0] Cells,
  output logic         Step,
  output logic         Ser_data,
  output logic         Ser_clk,
  output logic         Ser_latch,
  output logic [7:0]   Layer_sel,
  output logic         Blank,
  output logic         Overrun
);

  localparam int unsigned GenW = $clog2(GEN_DIV);
  localparam int unsigned DwW  = $clog2(DWELL_CYC + 1);

  scan_state_e           state_q;
  logic [CUBE_CELLS-1:0] frame_q;
  logic [2:0]            layer_q;
  logic [GenW-1:0]       gen_cnt_q;
  logic                  pending_q;
  logic                  overrun_q;
  logic [DwW-1:0]        dwell_cnt_q;
  logic                  step_q;
  logic                  latch_q;
  logic                  blank_q;
  logic [7:0]            layer_sel_q;

  logic       tick;
  logic       dwell_last;
  logic       shift_start;
  logic       shift_done;
  logic [5:0] bit_idx;
  logic       bit_in;

  assign tick        = Run && (gen_cnt_q == GenW'(GEN_DIV - 1));
  assign dwell_last  = dwell_cnt_q == DwW'(DWELL_CYC - 1);
  assign shift_start = (state_q == StCapture) ||
                       ((state_q == StDwell) && dwell_last && (layer_q != 3'(CUBE_H - 1)));
  // Bit n of a layer walks z in the upper three bits and x in the lower three.
  assign bit_in      = frame_q[cell_idx(bit_idx[2:0], layer_q, bit_idx[5:3])];

  cube_bit_shifter #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_shifter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (shift_start),
    .bit_in  (bit_in),
    .done    (shift_done),
    .bit_idx (bit_idx),
    .Ser_clk (Ser_clk),
    .Ser_data(Ser_data)
  );

  // Generation rate counter; ticks coalesce into a single pending step.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      gen_cnt_q <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (Run) begin
        gen_cnt_q <= tick ? '0 : gen_cnt_q + GenW'(1);
      end
      if (tick) begin
        pending_q <= 1'b1;
        // A tick landing on the STEP cycle replaces the one being consumed.
        if (pending_q && (state_q != StStep)) begin
          overrun_q <= 1'b1;
        end
      end else if (state_q == StStep) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Frame sequencing with registered Step/latch/blank/layer outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= StSync;
      frame_q     <= '0;
      layer_q     <= '0;
      dwell_cnt_q <= '0;
      step_q      <= 1'b0;
      latch_q     <= 1'b0;
      blank_q     <= 1'b1;
      layer_sel_q <= 8'h01;
    end else begin
      unique case (state_q)
        StSync: begin
          if (pending_q) begin
            state_q <= StStep;
            step_q  <= 1'b1;
          end else begin
            state_q <= StCapture;
          end
        end
        StStep: begin
          step_q  <= 1'b0;
          state_q <= StCapture;
        end
        StCapture: begin
          frame_q <= Cells;
          layer_q <= '0;
          state_q <= StShift;
        end
        StShift: begin
          if (shift_done) begin
            state_q     <= StLatch;
            latch_q     <= 1'b1;
            layer_sel_q <= 8'h01 << layer_q;
          end
        end
        StLatch: begin
          latch_q     <= 1'b0;
          blank_q     <= 1'b0;
          dwell_cnt_q <= '0;
          state_q     <= StDwell;
        end
        StDwell: begin
          if (dwell_last) begin
            blank_q <= 1'b1;
            if (layer_q == 3'(CUBE_H - 1)) begin
              state_q <= StSync;
            end else begin
              layer_q <= layer_q + 3'd1;
              state_q <= StShift;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q + DwW'(1);
          end
        end
        default: state_q <= StSync;
      endcase
    end
  end

  assign Step      = step_q;
  assign Ser_latch = latch_q;
  assign Layer_sel = layer_sel_q;
  assign Blank     = blank_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Scoreboard bench for cube_scan_ctrl: expected layers are queued by the stimulus and
// checked by a monitor at every Ser_latch pulse.
module tb_cube_scan_ctrl;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DWELL = 4;
  localparam int unsigned GDIV  = 10;

  logic         Clk;
  logic         Reset_n;
  logic         Run;
  logic [511:0] Cells;
  logic         Step;
  logic         Ser_data;
  logic         Ser_clk;
  logic         Ser_latch;
  logic [7:0]   Layer_sel;
  logic         Blank;
  logic         Overrun;

  cube_scan_ctrl #(
    .CLK_PER_BIT(CPB),
    .DWELL_CYC  (DWELL),
    .GEN_DIV    (GDIV)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Run      (Run),
    .Cells    (Cells),
    .Step     (Step),
    .Ser_data (Ser_data),
    .Ser_clk  (Ser_clk),
    .Ser_latch(Ser_latch),
    .Layer_sel(Layer_sel),
    .Blank    (Blank),
    .Overrun  (Overrun)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic [7:0]  sel;
    logic [63:0] row;
    int          steps;
    int          wins;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // Queue the first n_layers latches of a frame; rows are hand-derived per frame.
  task automatic push_frame(input logic [7:0][63:0] rows, input int n_layers, input int steps0,
                            input int wins0, input logic ovr0, input logic ovr_rest);
    for (int l = 0; l < n_layers; l++) begin
      exp_t x;
      x.sel   = 8'h01 << l;
      x.row   = rows[l];
      x.steps = (l == 0) ? steps0 : 0;
      x.wins  = (l == 0) ? wins0 : 1;
      x.ovr   = (l == 0) ? ovr0 : ovr_rest;
      exp_q.push_back(x);
    end
  endtask

  // Monitor: rebuilds each shifted row, counts Step pulses and dwell windows between latches.
  logic [63:0] m_row;
  int          m_bits, m_steps, m_wins, m_dwell;
  logic        m_prev_clk;
  exp_t        m_e;

  initial begin
    forever begin
      @(negedge Clk);
      if (Reset_n !== 1'b1) begin
        m_row = '0; m_bits = 0; m_steps = 0; m_wins = 0; m_dwell = 0; m_prev_clk = 1'b0;
      end else begin
        if (Ser_clk && !m_prev_clk) begin
          m_row = {m_row[62:0], Ser_data};
          m_bits++;
        end
        m_prev_clk = Ser_clk;
        if (Step) m_steps++;
        if (!Blank) begin
          m_dwell++;
        end else if (m_dwell != 0) begin
          check("dwell_len", 64'(m_dwell), 64'(DWELL));
          m_wins++;
          m_dwell = 0;
        end
        if (Ser_latch) begin
          check("latch_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            check("layer_sel", 64'(Layer_sel), 64'(m_e.sel));
            check("row_bits", m_row, m_e.row);
            check("bit_count", 64'(m_bits), 64'd64);
            check("steps_before", 64'(m_steps), 64'(m_e.steps));
            check("dwell_windows", 64'(m_wins), 64'(m_e.wins));
            check("overrun", 64'(Overrun), 64'(m_e.ovr));
          end
          m_row = '0; m_bits = 0; m_steps = 0; m_wins = 0;
        end
      end
    end
  end

  logic [7:0][63:0] rows_f1, rows_f2, rows_f3;
  logic [511:0]     p1, p2, p3;

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step"}, 64'(Step), 64'd0);
    check({tag, "_ser_clk"}, 64'(Ser_clk), 64'd0);
    check({tag, "_ser_data"}, 64'(Ser_data), 64'd0);
    check({tag, "_ser_latch"}, 64'(Ser_latch), 64'd0);
    check({tag, "_layer_sel"}, 64'(Layer_sel), 64'h01);
    check({tag, "_blank"}, 64'(Blank), 64'd1);
    check({tag, "_overrun"}, 64'(Overrun), 64'd0);
  endtask

  initial begin
    int t;
    // Single cells chosen so that x/z swaps or wrong layer land on different rows/bits.
    p1 = '0; p1[511] = 1'b1;               // x7 y7 z7 -> layer 7, n=63
    p2 = '0; p2[6] = 1'b1; p2[209] = 1'b1;  // x6 y0 z0 -> l0 n6; x1 y2 z3 -> l2 n25
    p3 = '0; p3[56] = 1'b1; p3[427] = 1'b1; // x0 y7 z0 -> l7 n0; x3 y5 z6 -> l5 n51
    rows_f1 = '0; rows_f1[7] = 64'h8000_0000_0000_0000;
    rows_f2 = '0; rows_f2[0] = 64'h0000_0000_0000_0040; rows_f2[2] = 64'h0000_0000_0200_0000;
    rows_f3 = '0; rows_f3[5] = 64'h0008_0000_0000_0000; rows_f3[7] = 64'h0000_0000_0000_0001;

    Reset_n = 1'b0;
    Run     = 1'b0;
    Cells   = p1;
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");

    push_frame(rows_f1, 8, 0, 0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    t = 0;
    do begin
      @(posedge Clk); #1; t++;
    end while (Ser_clk !== 1'b1 && t < 20);
    check("first_ser_clk_rise", 64'(t), 64'(CPB / 2 + 2));

    // New Cells during frame 1 must not appear before frame 2.
    t = 0;
    do begin @(negedge Clk); t++; end while (!Ser_latch && t < 5000);
    check("wait_latch_f1", 64'(Ser_latch), 64'd1);
    Cells = p2;
    push_frame(rows_f2, 8, 0, 1, 1'b0, 1'b1);

    // Skip to frame 2 layer 0 latch, then start generation ticks.
    for (int k = 0; k < 8; k++) begin
      t = 0;
      do begin @(negedge Clk); t++; end while (!Ser_latch && t < 5000);
      check("wait_latch_f2", 64'(Ser_latch), 64'd1);
    end
    Run = 1'b1;
    push_frame(rows_f3, 8, 1, 1, 1'b1, 1'b1);

    // The simulator updates Cells on the edge that samples Step.
    t = 0;
    do begin @(negedge Clk); t++; end while (!Step && t < 5000);
    check("saw_step_f3", 64'(Step), 64'd1);
    @(posedge Clk);
    #1 Cells = p3;
    push_frame(rows_f3, 1, 1, 1, 1'b1, 1'b1);

    t = 0;
    do begin @(posedge Clk); t++; end while (exp_q.size() != 0 && t < 25000);
    check("queue_drained_f4", 64'(exp_q.size()), 64'd0);

    // Reset while a serial bit is in its high half.
    t = 0;
    do begin @(negedge Clk); t++; end while (Ser_clk !== 1'b1 && t < 2000);
    check("wait_ser_clk_high", 64'(Ser_clk), 64'd1);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    check_reset_outputs("rst_shift");
    repeat (2) @(posedge Clk);
    push_frame(rows_f3, 8, 0, 0, 1'b1, 1'b1);
    #1 Reset_n = 1'b1;

    // Reset during the STEP cycle.
    t = 0;
    do begin @(negedge Clk); t++; end while (!Step && t < 5000);
    check("saw_step_f6", 64'(Step), 64'd1);
    check("queue_drained_f5", 64'(exp_q.size()), 64'd0);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    check("rst_step_step", 64'(Step), 64'd0);
    check("rst_step_blank", 64'(Blank), 64'd1);
    check("rst_step_layer_sel", 64'(Layer_sel), 64'h01);
    check("rst_step_ser_clk", 64'(Ser_clk), 64'd0);
    check("rst_step_overrun", 64'(Overrun), 64'd0);
    repeat (2) @(posedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
